// File: rtl/fetcher_if.sv
// Fetch-stage bus bundle: decoder handshake plus memory-controller refill port.
// The master modport belongs to the fetcher and the slave modport to its environment.
interface fetcher_if;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] f_next_pc;
  logic        f_ok;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done;
  logic [31:0] mc_data;

  modport master (
    output inst_valid, inst_addr, inst_data, mc_req, mc_addr,
    input  f_next_pc, f_ok, mc_done, mc_data
  );

  modport slave (
    input  inst_valid, inst_addr, inst_data, mc_req, mc_addr,
    output f_next_pc, f_ok, mc_done, mc_data
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the PC and a direct-mapped one-word-per-line I-cache,
// refills from the memory controller on a miss and hands one instruction at a time to the decoder.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IDX_BIT  = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  fetcher_if.master   bus
);

  localparam int unsigned Lines = 1 << IDX_BIT;
  localparam int unsigned TagW  = 32 - IDX_BIT - 2;

  typedef enum logic [1:0] {StFetch, StMiss, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic [IDX_BIT-1:0] pc_idx, fill_idx;
  logic [TagW-1:0]    pc_tag, fill_tag;
  logic               hit;
  logic               fill_en;

  assign pc_idx   = pc_q[IDX_BIT+1:2];
  assign pc_tag   = pc_q[31:IDX_BIT+2];
  // Fill uses the outstanding request address: pc may already hold a redirect target.
  assign fill_idx = mc_addr_q[IDX_BIT+1:2];
  assign fill_tag = mc_addr_q[31:IDX_BIT+2];
  assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign fill_en  = rdy_in && (state_q == StMiss) && bus.mc_done;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    inst_valid_d = inst_valid_q;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;

    if (rob_clear) begin
      pc_d         = rob_clear_pc;
      inst_valid_d = 1'b0;
      if (state_q == StMiss) begin
        // A redirect coinciding with the refill behaves like a discarded refill.
        if (bus.mc_done) begin
          mc_req_d  = 1'b0;
          discard_d = 1'b0;
          state_d   = StFetch;
        end else begin
          discard_d = 1'b1;
        end
      end else begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_addr_d  = pc_q;
            inst_data_d  = data_q[pc_idx];
            state_d      = StHold;
          end else begin
            mc_req_d  = 1'b1;
            mc_addr_d = {pc_q[31:2], 2'b00};
            state_d   = StMiss;
          end
        end
        StMiss: begin
          if (bus.mc_done) begin
            mc_req_d = 1'b0;
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StFetch;
            end else begin
              inst_valid_d = 1'b1;
              inst_addr_d  = pc_q;
              inst_data_d  = bus.mc_data;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (bus.f_ok) begin
            pc_d         = bus.f_next_pc;
            inst_valid_d = 1'b0;
            state_d      = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      inst_valid_q <= inst_valid_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mc_data;
    end
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_addr  = inst_addr_q;
  assign bus.inst_data  = inst_data_q;
  assign bus.mc_req     = mc_req_q;
  assign bus.mc_addr    = mc_addr_q;

endmodule
